ledmatrix_sequencer: RTL and testbench



---
 rtl/ledmatrix_sequencer_if.sv | 27 ++
 rtl/ledmatrix_sequencer.sv | 139 +++++++++++++
 tb/tb_ledmatrix_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ledmatrix_sequencer_if.sv
// Signal bundle between the LED matrix pattern sequencer and its surroundings.
// Controls and outputs are plain levels or strobes sampled on slow_clk; there is no backpressure.
interface ledmatrix_sequencer_if #(
    parameter int NUM_SEGS     = 8,
    parameter int LEDS_PER_SEG = 8,
    parameter int AW           = $clog2(NUM_SEGS)
);
    logic                             in_mode_next;
    logic                             in_pause;
    logic                             in_user_we;
    logic [AW-1:0]                    in_user_addr;
    logic [LEDS_PER_SEG-1:0]          in_user_data;
    logic [NUM_SEGS*LEDS_PER_SEG-1:0] out_bits;
    logic                             out_update;
    logic [1:0]                       out_mode;
    logic                             out_frame_tick;

    modport master (
        output in_mode_next, in_pause, in_user_we, in_user_addr, in_user_data,
        input  out_bits, out_update, out_mode, out_frame_tick
    );

    modport slave (
        input  in_mode_next, in_pause, in_user_we, in_user_addr, in_user_data,
        output out_bits, out_update, out_mode, out_frame_tick
    );
endinterface

// File: rtl/ledmatrix_sequencer.sv
// Frame pattern scheduler for the LED matrix driver: walking dot, binary count,
// row scan and a user-written frame buffer, with hold time, pause and mode stepping.
module ledmatrix_sequencer #(
    parameter int NUM_SEGS     = 8,
    parameter int LEDS_PER_SEG = 8,
    parameter int HOLD_TICKS   = 1
) (
    input  logic                  slow_clk,
    input  logic                  rst,
    ledmatrix_sequencer_if.slave  bus
);
    localparam int FRAME_BITS = NUM_SEGS * LEDS_PER_SEG;
    localparam int AW         = $clog2(NUM_SEGS);
    localparam int HW         = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [AW-1:0] ROW_LAST  = AW'(NUM_SEGS - 1);

    typedef enum logic [1:0] {
        MODE_WALK    = 2'd0,
        MODE_COUNT   = 2'd1,
        MODE_ROWSCAN = 2'd2,
        MODE_USER    = 2'd3
    } mode_t;

    mode_t                   r_mode;
    mode_t                   w_mode_nxt;
    logic [FRAME_BITS-1:0]   r_bits;
    logic [FRAME_BITS-1:0]   w_bits_nxt;
    logic [HW-1:0]           r_hold;
    logic [HW-1:0]           w_hold_nxt;
    logic [AW-1:0]           r_row;
    logic [AW-1:0]           w_row_nxt;
    logic [AW-1:0]           w_row_inc;
    logic [LEDS_PER_SEG-1:0] r_buf [NUM_SEGS];
    logic [FRAME_BITS-1:0]   w_buf_flat;
    logic                    r_btn_hist;
    logic                    r_update;
    logic                    r_tick;
    logic                    w_tick_nxt;
    logic                    w_mode_edge;
    logic                    w_hold_done;
    logic                    w_advance;

    // Full row of LEDs placed at the given row position, everything else dark.
    function automatic logic [FRAME_BITS-1:0] row_frame(input logic [AW-1:0] row);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[LEDS_PER_SEG-1:0] = '1;
        return f << (row * LEDS_PER_SEG);
    endfunction

    always_comb begin
        w_buf_flat = '0;
        for (int r = 0; r < NUM_SEGS; r++) begin
            w_buf_flat[r*LEDS_PER_SEG +: LEDS_PER_SEG] = r_buf[r];
        end
    end

    assign w_mode_edge = ~r_btn_hist & bus.in_mode_next;
    assign w_hold_done = (r_hold == HOLD_LAST);
    // A mode step always wins over a frame advance scheduled for the same edge.
    assign w_advance   = ~bus.in_pause & w_hold_done & ~w_mode_edge;
    assign w_row_inc   = (r_row == ROW_LAST) ? '0 : r_row + AW'(1);

    always_comb begin
        w_mode_nxt = r_mode;
        w_bits_nxt = r_bits;
        w_hold_nxt = r_hold;
        w_row_nxt  = r_row;
        w_tick_nxt = 1'b0;

        if (w_mode_edge) begin
            w_hold_nxt = '0;
            w_mode_nxt = mode_t'(r_mode + 2'd1);
            unique case (w_mode_nxt)
                MODE_WALK:    w_bits_nxt = FRAME_BITS'(1);
                MODE_COUNT:   w_bits_nxt = '0;
                MODE_ROWSCAN: begin
                    w_row_nxt  = '0;
                    w_bits_nxt = row_frame('0);
                end
                MODE_USER:    w_bits_nxt = w_buf_flat;
                default:      w_bits_nxt = r_bits;
            endcase
        end else begin
            if (!bus.in_pause) begin
                w_hold_nxt = w_hold_done ? '0 : r_hold + HW'(1);
            end
            if (w_advance) begin
                w_tick_nxt = 1'b1;
                unique case (r_mode)
                    MODE_WALK:    w_bits_nxt = {r_bits[FRAME_BITS-2:0], r_bits[FRAME_BITS-1]};
                    MODE_COUNT:   w_bits_nxt = r_bits + FRAME_BITS'(1);
                    MODE_ROWSCAN: begin
                        w_row_nxt  = w_row_inc;
                        w_bits_nxt = row_frame(w_row_inc);
                    end
                    MODE_USER:    w_bits_nxt = w_buf_flat;
                    default:      w_bits_nxt = r_bits;
                endcase
            end
            // USER mirrors the buffer every cycle so writes show up even while paused.
            if (r_mode == MODE_USER) begin
                w_bits_nxt = w_buf_flat;
            end
        end
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_mode     <= MODE_WALK;
            r_bits     <= FRAME_BITS'(1);
            r_hold     <= '0;
            r_row      <= '0;
            r_btn_hist <= 1'b1;
            r_update   <= 1'b0;
            r_tick     <= 1'b0;
            for (int r = 0; r < NUM_SEGS; r++) begin
                r_buf[r] <= '0;
            end
        end else begin
            r_mode     <= w_mode_nxt;
            r_bits     <= w_bits_nxt;
            r_hold     <= w_hold_nxt;
            r_row      <= w_row_nxt;
            r_btn_hist <= bus.in_mode_next;
            r_update   <= ~bus.in_pause;
            r_tick     <= w_tick_nxt;
            if (bus.in_user_we && (int'(bus.in_user_addr) < NUM_SEGS)) begin
                r_buf[bus.in_user_addr] <= bus.in_user_data;
            end
        end
    end

    assign bus.out_bits       = r_bits;
    assign bus.out_update     = r_update;
    assign bus.out_mode       = r_mode;
    assign bus.out_frame_tick = r_tick;
endmodule

// File: tb/tb_ledmatrix_sequencer.sv
// Self-checking bench for ledmatrix_sequencer: a default 8x8 instance with a one-tick
// hold and a narrow 2x2 instance with a three-tick hold for count wrap and mid-hold reset.
module tb_ledmatrix_sequencer;
    logic slow_clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [1:0]  mode_q[$];
    logic        tick_q[$];

    always #5 slow_clk = ~slow_clk;

    ledmatrix_sequencer_if #(.NUM_SEGS(8), .LEDS_PER_SEG(8)) bus_a ();
    ledmatrix_sequencer_if #(.NUM_SEGS(2), .LEDS_PER_SEG(2)) bus_b ();

    ledmatrix_sequencer #(.NUM_SEGS(8), .LEDS_PER_SEG(8), .HOLD_TICKS(1)) dut_a (
        .slow_clk (slow_clk),
        .rst      (rst_a),
        .bus      (bus_a.slave)
    );

    ledmatrix_sequencer #(.NUM_SEGS(2), .LEDS_PER_SEG(2), .HOLD_TICKS(3)) dut_b (
        .slow_clk (slow_clk),
        .rst      (rst_b),
        .bus      (bus_b.slave)
    );

    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
    endtask

    task automatic reset_b();
        rst_b = 1'b1;
        tick();
        tick();
        rst_b = 1'b0;
    endtask

    task automatic pulse_a();
        bus_a.in_mode_next = 1'b1;
        tick();
        bus_a.in_mode_next = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus_a.in_mode_next = 1'b1;
        rst_a = 1'b1;
        #1;
        n_checks += 4;
        if (bus_a.out_bits !== 64'd1) begin n_fail++; $display("FAIL reset_bits: got %h exp %h", bus_a.out_bits, 64'd1); end
        if (bus_a.out_mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d exp 0", bus_a.out_mode); end
        if (bus_a.out_update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b exp 0", bus_a.out_update); end
        if (bus_a.out_frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b exp 0", bus_a.out_frame_tick); end
        tick();
        tick();
        rst_a = 1'b0;
        repeat (10) tick();
        n_checks += 2;
        if (bus_a.out_mode !== 2'd0) begin n_fail++; $display("FAIL held_button_mode: got %0d exp 0", bus_a.out_mode); end
        if (bus_a.out_update !== 1'b1) begin n_fail++; $display("FAIL update_after_reset: got %b exp 1", bus_a.out_update); end
        bus_a.in_mode_next = 1'b0;
    endtask

    task automatic test_walk();
        logic [63:0] exp;
        logic [63:0] got;
        reset_a();
        exp = 64'd1;
        for (int i = 0; i < 70; i++) begin
            exp = (exp == 64'h8000_0000_0000_0000) ? 64'd1 : (exp << 1);
            exp_q.push_back(exp);
            tick();
            got = exp_q.pop_front();
            n_checks += 2;
            if (bus_a.out_bits !== got) begin n_fail++; $display("FAIL walk_bits[%0d]: got %h exp %h", i, bus_a.out_bits, got); end
            if (bus_a.out_frame_tick !== 1'b1) begin n_fail++; $display("FAIL walk_tick[%0d]: got %b exp 1", i, bus_a.out_frame_tick); end
        end
    endtask

    task automatic test_pause();
        reset_a();
        repeat (3) tick();
        n_checks++;
        if (bus_a.out_bits !== 64'd8) begin n_fail++; $display("FAIL pause_pre: got %h exp 8", bus_a.out_bits); end
        bus_a.in_pause = 1'b1;
        tick();
        n_checks += 3;
        if (bus_a.out_bits !== 64'd8) begin n_fail++; $display("FAIL pause_hold: got %h exp 8", bus_a.out_bits); end
        if (bus_a.out_update !== 1'b0) begin n_fail++; $display("FAIL pause_update: got %b exp 0", bus_a.out_update); end
        if (bus_a.out_frame_tick !== 1'b0) begin n_fail++; $display("FAIL pause_tick: got %b exp 0", bus_a.out_frame_tick); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus_a.out_bits !== 64'd8) begin n_fail++; $display("FAIL pause_stay[%0d]: got %h exp 8", i, bus_a.out_bits); end
        end
        bus_a.in_mode_next = 1'b1;
        tick();
        bus_a.in_mode_next = 1'b0;
        n_checks += 2;
        if (bus_a.out_mode !== 2'd1) begin n_fail++; $display("FAIL pause_mode: got %0d exp 1", bus_a.out_mode); end
        if (bus_a.out_bits !== 64'd0) begin n_fail++; $display("FAIL pause_mode_entry: got %h exp 0", bus_a.out_bits); end
        tick();
        n_checks++;
        if (bus_a.out_bits !== 64'd0) begin n_fail++; $display("FAIL pause_count_hold: got %h exp 0", bus_a.out_bits); end
        bus_a.in_pause = 1'b0;
        tick();
        n_checks += 3;
        if (bus_a.out_bits !== 64'd1) begin n_fail++; $display("FAIL resume_bits: got %h exp 1", bus_a.out_bits); end
        if (bus_a.out_frame_tick !== 1'b1) begin n_fail++; $display("FAIL resume_tick: got %b exp 1", bus_a.out_frame_tick); end
        if (bus_a.out_update !== 1'b1) begin n_fail++; $display("FAIL resume_update: got %b exp 1", bus_a.out_update); end
    endtask

    task automatic test_mode_cycle();
        logic [1:0]  pm [4];
        logic [63:0] pb [4];
        logic [1:0]  gm;
        logic [63:0] gb;
        pm = '{2'd1, 2'd2, 2'd3, 2'd0};
        pb = '{64'd0, 64'hFF, 64'd0, 64'd1};
        reset_a();
        tick();
        bus_a.in_mode_next = 1'b1;
        repeat (10) tick();
        bus_a.in_mode_next = 1'b0;
        n_checks++;
        if (bus_a.out_mode !== 2'd1) begin n_fail++; $display("FAIL long_press_mode: got %0d exp 1", bus_a.out_mode); end
        reset_a();
        tick();
        for (int i = 0; i < 4; i++) begin
            mode_q.push_back(pm[i]);
            exp_q.push_back(pb[i]);
            bus_a.in_mode_next = 1'b1;
            tick();
            gm = mode_q.pop_front();
            gb = exp_q.pop_front();
            n_checks += 3;
            if (bus_a.out_mode !== gm) begin n_fail++; $display("FAIL cycle_mode[%0d]: got %0d exp %0d", i, bus_a.out_mode, gm); end
            if (bus_a.out_bits !== gb) begin n_fail++; $display("FAIL cycle_entry[%0d]: got %h exp %h", i, bus_a.out_bits, gb); end
            if (bus_a.out_frame_tick !== 1'b0) begin n_fail++; $display("FAIL cycle_tick[%0d]: got %b exp 0", i, bus_a.out_frame_tick); end
            bus_a.in_mode_next = 1'b0;
            tick();
            if (i == 1) begin
                n_checks++;
                if (bus_a.out_bits !== 64'hFF00) begin n_fail++; $display("FAIL rowscan_next: got %h exp ff00", bus_a.out_bits); end
            end
        end
    endtask

    task automatic test_user();
        logic [63:0] got;
        reset_a();
        tick();
        repeat (3) pulse_a();
        n_checks += 2;
        if (bus_a.out_mode !== 2'd3) begin n_fail++; $display("FAIL user_mode: got %0d exp 3", bus_a.out_mode); end
        if (bus_a.out_bits !== 64'd0) begin n_fail++; $display("FAIL user_entry: got %h exp 0", bus_a.out_bits); end
        bus_a.in_user_we   = 1'b1;
        bus_a.in_user_addr = 3'd3;
        bus_a.in_user_data = 8'hA5;
        exp_q.push_back(64'hA5 << 24);
        tick();
        bus_a.in_user_data = 8'h5A;
        exp_q.push_back(64'h5A << 24);
        tick();
        bus_a.in_user_we = 1'b0;
        got = exp_q.pop_front();
        n_checks++;
        if (bus_a.out_bits !== got) begin n_fail++; $display("FAIL user_first: got %h exp %h", bus_a.out_bits, got); end
        tick();
        got = exp_q.pop_front();
        n_checks++;
        if (bus_a.out_bits !== got) begin n_fail++; $display("FAIL user_last_wins: got %h exp %h", bus_a.out_bits, got); end
        bus_a.in_pause     = 1'b1;
        bus_a.in_user_we   = 1'b1;
        bus_a.in_user_addr = 3'd0;
        bus_a.in_user_data = 8'h3C;
        exp_q.push_back((64'h5A << 24) | 64'h3C);
        tick();
        bus_a.in_user_we = 1'b0;
        tick();
        got = exp_q.pop_front();
        n_checks++;
        if (bus_a.out_bits !== got) begin n_fail++; $display("FAIL user_paused_write: got %h exp %h", bus_a.out_bits, got); end
        bus_a.in_pause = 1'b0;
    endtask

    task automatic test_count_wrap();
        int          hold_m;
        logic [3:0]  val;
        logic        t;
        logic [63:0] gb;
        logic        gt;
        reset_b();
        tick();
        bus_b.in_mode_next = 1'b1;
        tick();
        bus_b.in_mode_next = 1'b0;
        n_checks += 3;
        if (bus_b.out_mode !== 2'd1) begin n_fail++; $display("FAIL count_mode: got %0d exp 1", bus_b.out_mode); end
        if (bus_b.out_bits !== 4'd0) begin n_fail++; $display("FAIL count_entry: got %h exp 0", bus_b.out_bits); end
        if (bus_b.out_frame_tick !== 1'b0) begin n_fail++; $display("FAIL count_entry_tick: got %b exp 0", bus_b.out_frame_tick); end
        hold_m = 0;
        val    = 4'd0;
        for (int i = 0; i < 51; i++) begin
            if (hold_m == 2) begin
                val    = val + 4'd1;
                t      = 1'b1;
                hold_m = 0;
            end else begin
                t      = 1'b0;
                hold_m = hold_m + 1;
            end
            exp_q.push_back({60'd0, val});
            tick_q.push_back(t);
            tick();
            gb = exp_q.pop_front();
            gt = tick_q.pop_front();
            n_checks += 2;
            if (bus_b.out_bits !== gb[3:0]) begin n_fail++; $display("FAIL count_bits[%0d]: got %h exp %h", i, bus_b.out_bits, gb[3:0]); end
            if (bus_b.out_frame_tick !== gt) begin n_fail++; $display("FAIL count_tick[%0d]: got %b exp %b", i, bus_b.out_frame_tick, gt); end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] eb [3];
        logic       et [3];
        logic [63:0] gb;
        logic        gt;
        eb = '{4'd1, 4'd1, 4'd2};
        et = '{1'b0, 1'b0, 1'b1};
        reset_b();
        tick();
        bus_b.in_mode_next = 1'b1;
        tick();
        bus_b.in_mode_next = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus_b.out_mode !== 2'd1) begin n_fail++; $display("FAIL mid_pre_mode: got %0d exp 1", bus_b.out_mode); end
        rst_b = 1'b1;
        #1;
        n_checks += 4;
        if (bus_b.out_bits !== 4'd1) begin n_fail++; $display("FAIL mid_reset_bits: got %h exp 1", bus_b.out_bits); end
        if (bus_b.out_mode !== 2'd0) begin n_fail++; $display("FAIL mid_reset_mode: got %0d exp 0", bus_b.out_mode); end
        if (bus_b.out_update !== 1'b0) begin n_fail++; $display("FAIL mid_reset_update: got %b exp 0", bus_b.out_update); end
        if (bus_b.out_frame_tick !== 1'b0) begin n_fail++; $display("FAIL mid_reset_tick: got %b exp 0", bus_b.out_frame_tick); end
        tick();
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({60'd0, eb[i]});
            tick_q.push_back(et[i]);
            tick();
            gb = exp_q.pop_front();
            gt = tick_q.pop_front();
            n_checks += 2;
            if (bus_b.out_bits !== gb[3:0]) begin n_fail++; $display("FAIL mid_release_bits[%0d]: got %h exp %h", i, bus_b.out_bits, gb[3:0]); end
            if (bus_b.out_frame_tick !== gt) begin n_fail++; $display("FAIL mid_release_tick[%0d]: got %b exp %b", i, bus_b.out_frame_tick, gt); end
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.in_mode_next = 1'b0;
        bus_a.in_pause     = 1'b0;
        bus_a.in_user_we   = 1'b0;
        bus_a.in_user_addr = '0;
        bus_a.in_user_data = '0;
        bus_b.in_mode_next = 1'b0;
        bus_b.in_pause     = 1'b0;
        bus_b.in_user_we   = 1'b0;
        bus_b.in_user_addr = '0;
        bus_b.in_user_data = 2'($urandom_range(0, 3));
        test_reset();
        test_walk();
        test_pause();
        test_mode_cycle();
        test_user();
        test_count_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
